// File: rtl/tx_resp_packer.sv
// Response packer: queues 8-bit read data and 16-bit ALU results as a byte stream
// and presents them one at a time to the TX synchronizer, closed by the synced UART busy.
//
// state   | meaning
// IDLE    | wait for a queued byte and busy low, then pop and present it
// PRESENT | tx_valid held; wait for busy rise or give up after BUSY_TO cycles
// DRAIN   | tx_valid low; wait for busy to fall
module tx_resp_packer #(
  parameter int DEPTH   = 8,
  parameter int BUSY_TO = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rd_data,
  input  logic        rd_vld,
  input  logic [15:0] alu_out,
  input  logic        alu_vld,
  input  logic        busy_sync,
  input  logic        clr_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        full,
  output logic        ovf,
  output logic        to_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, alu_ptr;
  logic [CW-1:0]   count, free_slots, free_after_rd, push_cnt;
  logic [TW-1:0]   timer;
  logic            rd_acc, alu_acc, drop;
  logic            pop, timer_load, timer_dec, timeout, tx_valid_nxt;

  // Admission uses the count at the start of the cycle; a same-cycle pop is not credited.
  always_comb begin
    free_slots    = CW'(DEPTH) - count;
    rd_acc        = rd_vld && (free_slots != '0);
    free_after_rd = free_slots - {{(CW-1){1'b0}}, rd_acc};
    alu_acc       = alu_vld && (free_after_rd >= CW'(2));
    drop          = (rd_vld && !rd_acc) || (alu_vld && !alu_acc);
    push_cnt      = {{(CW-1){1'b0}}, rd_acc} + (alu_acc ? CW'(2) : CW'(0));
    alu_ptr       = wr_ptr + {{(AW-1){1'b0}}, rd_acc};
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    timeout      = 1'b0;
    tx_valid_nxt = tx_valid;
    case (state)
      IDLE: begin
        if ((count != '0) && !busy_sync) begin
          pop          = 1'b1;
          timer_load   = 1'b1;
          tx_valid_nxt = 1'b1;
          state_nxt    = PRESENT;
        end
      end
      PRESENT: begin
        if (busy_sync) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = DRAIN;
        end else if (timer == '0) begin
          timeout      = 1'b1;
          tx_valid_nxt = 1'b0;
          state_nxt    = DRAIN;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DRAIN: begin
        tx_valid_nxt = 1'b0;
        if (!busy_sync) state_nxt = IDLE;
      end
      default: begin
        tx_valid_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      ovf      <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_valid <= tx_valid_nxt;
      wr_ptr   <= wr_ptr + push_cnt[AW-1:0];
      count    <= count + push_cnt - {{(CW-1){1'b0}}, pop};
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      // Down-counter: loaded with BUSY_TO-1, terminal count at zero.
      if (timer_load)     timer <= TW'(BUSY_TO - 1);
      else if (timer_dec) timer <= timer - TW'(1);
      if (drop)         ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (timeout)      to_err <= 1'b1;
      else if (clr_err) to_err <= 1'b0;
    end
  end

  // Only free slots are written, so the head being popped is never overwritten.
  always_ff @(posedge clk) begin
    if (rd_acc) mem[wr_ptr] <= rd_data;
    if (alu_acc) begin
      mem[alu_ptr]          <= alu_out[7:0];
      mem[alu_ptr + AW'(1)] <= alu_out[15:8];
    end
  end

  assign full = (count == CW'(DEPTH));

endmodule

// File: tb/tb_tx_resp_packer.sv
// Bench for tx_resp_packer: directed scenarios plus random traffic, checked by a
// queue-based reference model and an independent output monitor.
module tb_tx_resp_packer;
  localparam int DEPTH   = 8;
  localparam int BUSY_TO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_vld = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_vld = 1'b0;
  logic        busy_sync = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid, full, ovf, to_err;

  int tests = 0;
  int fails = 0;
  byte unsigned sb[$];
  bit exp_ovf = 1'b0;
  bit exp_to_err = 1'b0;
  bit auto_busy = 1'b0;

  tx_resp_packer #(.DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_data(rd_data), .rd_vld(rd_vld),
    .alu_out(alu_out), .alu_vld(alu_vld), .busy_sync(busy_sync), .clr_err(clr_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .full(full), .ovf(ovf), .to_err(to_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes accepted in push order, each item all-or-nothing.
  initial begin
    int free;
    bit rd_ok, alu_ok;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_ovf = 1'b0;
      end else begin
        free   = DEPTH - sb.size();
        rd_ok  = rd_vld && (free >= 1);
        alu_ok = alu_vld && ((free - int'(rd_ok)) >= 2);
        if (rd_ok) sb.push_back(rd_data);
        if (alu_ok) begin
          sb.push_back(alu_out[7:0]);
          sb.push_back(alu_out[15:8]);
        end
        if ((rd_vld && !rd_ok) || (alu_vld && !alu_ok)) exp_ovf = 1'b1;
        else if (clr_err) exp_ovf = 1'b0;
      end
    end
  end

  // Monitor: pops on every TX_VALID rise and checks the handshake rules each cycle.
  initial begin
    bit pv, tmo;
    int hi;
    byte unsigned held, exp_b;
    pv = 1'b0; hi = 0; held = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pv = 1'b0;
        exp_to_err = 1'b0;
        continue;
      end
      tmo = 1'b0;
      if (pv) begin
        if (busy_sync) check("fall_on_busy", tx_valid, 0);
        else if (hi + 1 == BUSY_TO) begin
          tmo = 1'b1;
          check("fall_on_timeout", tx_valid, 0);
        end else begin
          check("valid_hold", tx_valid, 1);
          check("data_hold", tx_data, held);
        end
        hi++;
      end else if (tx_valid) begin
        check("rise_busy_low", busy_sync, 0);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL rise_empty: got byte 0x%0h expected no byte at %0t", tx_data, $time);
        end else begin
          exp_b = sb.pop_front();
          check("byte_order", tx_data, exp_b);
        end
        held = tx_data;
        hi = 0;
      end
      if (tmo) exp_to_err = 1'b1;
      else if (clr_err) exp_to_err = 1'b0;
      check("to_err", to_err, exp_to_err);
      check("ovf", ovf, exp_ovf);
      check("full", full, sb.size() == DEPTH);
      pv = tx_valid;
    end
  end

  // Random UART responder used during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_busy && tx_valid && !busy_sync) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        busy_sync = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        busy_sync = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic push_rd(input logic [7:0] b);
    @(negedge clk);
    rd_data = b; rd_vld = 1'b1;
    @(negedge clk);
    rd_vld = 1'b0;
  endtask

  task automatic push_both(input logic [7:0] b, input logic [15:0] a, input bit do_rd, input bit do_alu);
    @(negedge clk);
    rd_data = b; rd_vld = do_rd; alu_out = a; alu_vld = do_alu;
    @(negedge clk);
    rd_vld = 1'b0; alu_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        ok = 1'b1;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL wait_valid: got no TX_VALID expected one within %0d cycles", budget);
  endtask

  task automatic serve(input logic [7:0] exp, input string name);
    bit ok;
    wait_valid(64, ok);
    if (ok) begin
      check(name, tx_data, exp);
      @(negedge clk);
      busy_sync = 1'b1;
      @(posedge clk); #1;
      check({name, "_fall"}, tx_valid, 0);
      @(negedge clk);
      busy_sync = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] exp_bytes [8];
    int budget;

    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_to_err", to_err, 0);
    rst_n = 1'b1;

    // Single RD byte: 2-cycle latency, falls one cycle after busy, no second byte.
    @(negedge clk);
    rd_data = 8'hA5; rd_vld = 1'b1;
    @(posedge clk); #1;
    check("lat_edge_n", tx_valid, 0);
    @(negedge clk);
    rd_vld = 1'b0;
    @(posedge clk); #1;
    check("lat_valid", tx_valid, 1);
    check("lat_data", tx_data, 8'hA5);
    repeat (20) @(negedge clk);
    busy_sync = 1'b1;
    @(posedge clk); #1;
    check("a5_fall", tx_valid, 0);
    repeat (100) @(negedge clk);
    busy_sync = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("no_second_byte", tx_valid, 0);

    // ALU result: low byte then high byte.
    push_both(8'h00, 16'h1234, 1'b0, 1'b1);
    serve(8'h34, "alu_lo");
    serve(8'h12, "alu_hi");

    // Stale busy: fill, combined RD+ALU with 2 free slots, then overflow.
    @(negedge clk);
    busy_sync = 1'b1;
    for (int i = 0; i < 6; i++) push_rd(8'h10 + 8'(i));
    push_both(8'h77, 16'hBEEF, 1'b1, 1'b1);
    check("combo_ovf", ovf, 1);
    check("combo_not_full", full, 0);
    pulse_clr();
    check("clr_ovf", ovf, 0);
    push_rd(8'h88);
    check("fill_full", full, 1);
    @(negedge clk);
    rd_data = 8'h99; rd_vld = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    rd_vld = 1'b0; clr_err = 1'b0;
    check("ovf_set_wins", ovf, 1);
    check("stale_busy_no_valid", tx_valid, 0);
    pulse_clr();
    @(negedge clk);
    busy_sync = 1'b0;
    for (int i = 0; i < 6; i++) exp_bytes[i] = 8'h10 + 8'(i);
    exp_bytes[6] = 8'h77;
    exp_bytes[7] = 8'h88;
    for (int i = 0; i < 8; i++) serve(exp_bytes[i], "fill1_byte");

    // Second fill across the pointer wrap.
    @(negedge clk);
    busy_sync = 1'b1;
    for (int i = 0; i < 8; i++) push_rd(8'hC0 + 8'(i));
    check("fill2_full", full, 1);
    @(negedge clk);
    busy_sync = 1'b0;
    for (int i = 0; i < 8; i++) serve(8'hC0 + 8'(i), "fill2_byte");

    // Busy timeout after exactly BUSY_TO cycles, then the next byte goes out.
    push_rd(8'h3C);
    wait_valid(8, ok);
    check("to_first_data", tx_data, 8'h3C);
    push_rd(8'hC3);
    repeat (BUSY_TO - 2) @(posedge clk);
    #1;
    check("to_still_valid", tx_valid, 1);
    check("to_not_yet", to_err, 0);
    @(posedge clk); #1;
    check("to_valid_low", tx_valid, 0);
    check("to_err_set", to_err, 1);
    pulse_clr();
    check("to_err_clr", to_err, 0);
    serve(8'hC3, "after_to");

    // Reset while presenting with 3 bytes queued.
    for (int i = 0; i < 4; i++) push_rd(8'h50 + 8'(i));
    check("pre_rst_valid", tx_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_full", full, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_to_err", to_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_valid", tx_valid, 0);
    check("post_rst_empty", full, 0);

    // Random traffic with a random responder.
    auto_busy = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      rd_vld  = ($urandom_range(0, 3) == 0);
      rd_data = 8'($urandom);
      alu_vld = ($urandom_range(0, 5) == 0);
      alu_out = 16'($urandom);
      clr_err = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    rd_vld = 1'b0; alu_vld = 1'b0; clr_err = 1'b0;
    budget = 0;
    while (!(sb.size() == 0 && !tx_valid && !busy_sync) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      tests++; fails++;
      $display("FAIL drain: got %0d bytes left expected 0 within 2000 cycles", sb.size());
    end
    auto_busy = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_resp_packer.md
# tx_resp_packer

Single-clock response packer in the REF_CLK control domain. It sits between the register-file/ALU result sources and the TX data synchronizer, directly upstream of the UART transmit path. It queues 8-bit read responses and 16-bit ALU results as a byte stream in a small FIFO. It presents one byte at a time to the slower TX_CLK domain using a level-hold handshake closed by the synchronized UART busy flag.

## Interface
- DEPTH, 8: byte FIFO depth; power of two, minimum 4.
- BUSY_TO, 1024: maximum REF_CLK cycles to wait for BUSY_SYNC to rise after presenting a byte.
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  reset; asynchronous assert, active-low.
- RD_DATA  in  8  register-file read data.
- RD_VLD  in  1  one-cycle strobe qualifying RD_DATA.
- ALU_OUT  in  16  ALU result.
- ALU_VLD  in  1  one-cycle strobe qualifying ALU_OUT.
- BUSY_SYNC  in  1  UART TX busy, already synchronized to CLK.
- CLR_ERR  in  1  clears the OVF and TO_ERR sticky flags.
- TX_DATA  out  8  byte presented to the TX data synchronizer; registered.
- TX_VALID  out  1  level valid toward the TX data synchronizer; registered.
- FULL  out  1  FIFO count equals DEPTH.
- OVF  out  1  sticky: a response was dropped for lack of space.
- TO_ERR  out  1  sticky: a byte was abandoned on busy timeout.

## Operation
- Push order within one cycle: the RD byte first, then the ALU low byte, then the ALU high byte.
- Each item is all-or-nothing:
  - An RD item needs 1 free slot.
  - An ALU item needs 2 free slots.
- Free slots are DEPTH minus count at the start of the cycle.
  - A pop in the same cycle is not credited.
  - When RD_VLD and ALU_VLD are both set, the ALU item is checked against the slots left after the RD item is accepted.
- A rejected item is discarded whole and sets OVF. There is never a partial ALU write.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- FSM states:
  - IDLE: if count>0 and BUSY_SYNC=0, load TX_DATA from the FIFO head, pop, set TX_VALID=1, clear the timer, and go to PRESENT. If BUSY_SYNC=1 (stale busy), hold in IDLE.
  - PRESENT: hold TX_VALID=1 and TX_DATA stable. The timer increments each cycle.
    - If BUSY_SYNC=1, go to DRAIN with TX_VALID=0.
    - Else if the timer reaches BUSY_TO-1, set TO_ERR, set TX_VALID=0, and go to DRAIN. The byte is lost and is not retried.
  - DRAIN: TX_VALID=0. When BUSY_SYNC=0, go to IDLE.
- TX_DATA keeps its last value outside PRESENT.
- CLR_ERR clears OVF and TO_ERR. If a set condition occurs in the same cycle, the set wins.
- Asserting RST mid-operation immediately empties the FIFO, forces IDLE, and clears all outputs. A byte in PRESENT is lost.

## Timing
- Reset values: TX_DATA=0, TX_VALID=0, FULL=0, OVF=0, TO_ERR=0, state IDLE, pointers and count 0.
- Latency from push to TX_VALID, with the FIFO empty, in IDLE and BUSY_SYNC=0:
  - A strobe at edge N writes the FIFO; count>0 is visible after N.
  - At edge N+1, TX_VALID=1 and TX_DATA=byte.
  - Latency is therefore 2 cycles.
- TX_VALID falls on the edge after BUSY_SYNC is first sampled high in PRESENT.
- Minimum gap between consecutive TX_VALID rises:
  - 1 cycle in PRESENT (BUSY_SYNC already high)
  - plus 1 cycle in DRAIN (BUSY_SYNC already low)
  - plus 1 cycle in IDLE, i.e. 3 cycles.
- FULL and count update on the same edge as the push or pop.

## Test plan
- After reset, push RD_DATA=0xA5. Expect TX_VALID=1 and TX_DATA=0xA5 two cycles later. Raise BUSY_SYNC 20 cycles later, then drop it 100 cycles after that. Expect TX_VALID=0 one cycle after the rise and no second byte.
- ALU_VLD with ALU_OUT=0x1234. Expect bytes 0x34 then 0x12, each held until busy is seen, then drained.
- RD_VLD and ALU_VLD in the same cycle (0x77, 0xBEEF) with 2 free slots. Expect 0x77 accepted, the ALU item dropped whole, and OVF=1. Pulse CLR_ERR and expect OVF=0.
- Fill 8 bytes with BUSY_SYNC stuck at 1. Expect FULL=1, no TX_VALID while busy is stale, and a further RD_VLD sets OVF. Release busy and expect 8 bytes in push order, with pointer wrap verified across a second fill.
- Present a byte with BUSY_SYNC held at 0. Expect TO_ERR=1 and TX_VALID=0 after exactly 1024 cycles, and the next queued byte then presented.
- Assert RST while in PRESENT with 3 bytes queued. Expect all outputs 0 immediately, and after release FIFO empty with no TX_VALID.
